// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage:
// state encoding, the NOP encoding and the default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HOLD   = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: request/address out,
// ack/data back in the cycle the read completes.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ack;
    logic [31:0]           data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold,
// and with none of them asserted the slot becomes a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_load,
    input  logic                  i_hold,
    input  logic [31:0]           i_instr,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    output logic [31:0]           o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic                  o_valid
);

    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] r_pc_plus4;
    logic                  r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end else if (!i_hold) begin
            r_valid <= 1'b0;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem requests, skid buffer and redirect squash.
// FETCH_STATS_EN adds fetch/squash counter outputs.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    instruction_fetch_if.master   imem,
    output logic [31:0]           o_instruction,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic                  o_instr_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]           o_fetch_count,
    output logic [31:0]           o_squash_count
`endif
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [ADDR_WIDTH-1:0] w_req_addr_nxt;
    logic [31:0]           r_skid;
    logic [31:0]           w_skid_nxt;
    logic [ADDR_WIDTH-1:0] w_rpc;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_ack;
    logic                  w_load;
    logic [31:0]           w_load_instr;
    logic [ADDR_WIDTH-1:0] w_load_pc4;
    logic                  w_unused;

    assign w_rpc      = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused   = ^i_redirect_pc[1:0];
    assign w_addr_inc = r_req_addr + ADDR_WIDTH'(4);

    // Request is gated by reset so a late ack is never taken.
    assign imem.req  = !i_rst && (r_state != HOLD);
    assign imem.addr = r_req_addr;
    assign w_ack     = imem.req && imem.ack;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_skid     <= NOP_INSTR;
        end else begin
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_skid     <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_skid_nxt     = r_skid;
        w_load         = 1'b0;
        w_load_instr   = imem.data;
        w_load_pc4     = w_addr_inc;
        unique case (r_state)
            FETCH: begin
                if (i_redirect) begin
                    w_pc_nxt = w_rpc;
                    if (w_ack) begin
                        w_req_addr_nxt = w_rpc;
                    end else begin
                        w_state_nxt = SQUASH;
                    end
                end else if (w_ack) begin
                    w_pc_nxt       = w_addr_inc;
                    w_req_addr_nxt = w_addr_inc;
                    if (i_stall) begin
                        w_skid_nxt  = imem.data;
                        w_state_nxt = HOLD;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            SQUASH: begin
                if (i_redirect) begin
                    w_pc_nxt = w_rpc;
                end
                if (w_ack) begin
                    w_req_addr_nxt = w_pc_nxt;
                    w_state_nxt    = FETCH;
                end
            end
            HOLD: begin
                // Request address already advanced past the buffered word.
                w_load_instr = r_skid;
                w_load_pc4   = r_req_addr;
                if (i_redirect) begin
                    w_pc_nxt       = w_rpc;
                    w_req_addr_nxt = w_rpc;
                    w_state_nxt    = FETCH;
                end else if (!i_stall) begin
                    w_load      = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_if_id (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (i_redirect),
        .i_load     (w_load),
        .i_hold     (i_stall),
        .i_instr    (w_load_instr),
        .i_pc_plus4 (w_load_pc4),
        .o_instr    (o_instruction),
        .o_pc_plus4 (o_pc_plus4),
        .o_valid    (o_instr_valid)
    );

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_squash_count;
    logic        w_discard;

    assign w_discard = w_ack &&
                       ((r_state == SQUASH) ||
                        (r_state == FETCH && i_redirect));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_count  <= '0;
            r_squash_count <= '0;
        end else begin
            if (w_load) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_discard) begin
                r_squash_count <= r_squash_count + 32'd1;
            end
        end
    end

    assign o_fetch_count  = r_fetch_count;
    assign o_squash_count = r_squash_count;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cases plus a random
// run scored against an in-order program-stream model.
module tb_instruction_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] instr2;
    logic [31:0] pc42;
    logic        valid2;
`ifdef FETCH_STATS_EN
    logic [31:0] fcnt;
    logic [31:0] scnt;
    logic [31:0] fcnt2;
    logic [31:0] scnt2;
`endif

    int total = 0;
    int bad = 0;

    instruction_fetch_if #(.ADDR_WIDTH(32)) mif ();
    instruction_fetch_if #(.ADDR_WIDTH(32)) mif2 ();

    always #5 clk = ~clk;

    instruction_fetch #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (rpc),
        .imem          (mif.master),
        .o_instruction (instr),
        .o_pc_plus4    (pc4),
        .o_instr_valid (valid)
`ifdef FETCH_STATS_EN
        ,
        .o_fetch_count  (fcnt),
        .o_squash_count (scnt)
`endif
    );

    instruction_fetch #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'hFFFF_FFFC)
    ) dut2 (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (1'b0),
        .i_redirect    (1'b0),
        .i_redirect_pc (32'h0),
        .imem          (mif2.master),
        .o_instruction (instr2),
        .o_pc_plus4    (pc42),
        .o_instr_valid (valid2)
`ifdef FETCH_STATS_EN
        ,
        .o_fetch_count  (fcnt2),
        .o_squash_count (scnt2)
`endif
    );

    assign mif2.ack  = mif2.req;
    assign mif2.data = ~mif2.addr;

    // Memory model: wait states per request, data = addr ^ key.
    logic [31:0] key = 32'h0;
    int          fixed_wait = 0;
    logic [31:0] slow_addr = 32'h1;
    int          slow_wait = 0;
    bit          busy = 1'b0;
    int          cnt = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ key;
    endfunction

    always @(posedge clk) begin
        #2;
        if (rst) busy = 1'b0;
        mif.ack  = 1'b0;
        mif.data = 32'hDEAD_BEEF;
        if (mif.req) begin
            if (!busy) begin
                busy = 1'b1;
                if (mif.addr == slow_addr) cnt = slow_wait;
                else if (fixed_wait >= 0) cnt = fixed_wait;
                else if ($urandom_range(0, 2) == 0) cnt = int'($urandom_range(1, 3));
                else cnt = 0;
            end
            if (cnt == 0) begin
                mif.ack  = 1'b1;
                mif.data = memword(mif.addr);
                busy     = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard queue of the program stream the decoder should see.
    exp_t        q[$];
    logic [31:0] push_pc = 32'h0;
    bit          sb_en = 1'b0;
    int          consumed = 0;

    task automatic refill();
        exp_t e;
        while (q.size() < 48) begin
            e.instr = memword(push_pc);
            e.pc4   = push_pc + 32'd4;
            q.push_back(e);
            push_pc = push_pc + 32'd4;
        end
    endtask

    logic        p_rst = 1'b1;
    logic        p_stall = 1'b0;
    logic        p_redir = 1'b0;
    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic        p_valid = 1'b0;
    logic [31:0] p_addr = 32'h0;
    logic [31:0] p_instr = 32'h0;
    logic [31:0] p_pc4 = 32'h0;

    always @(negedge clk) begin
        exp_t e;
        if (!p_rst && !rst) begin
            if (p_redir) begin
                chk("flush_instr", instr, 32'h0);
                chk("flush_valid", 32'(valid), 32'h0);
            end else if (p_stall) begin
                chk("hold_instr", instr, p_instr);
                chk("hold_pc4", pc4, p_pc4);
                chk("hold_valid", 32'(valid), 32'(p_valid));
            end
            if (p_req && !p_ack) begin
                chk("req_held", 32'(mif.req), 32'h1);
                chk("addr_held", mif.addr, p_addr);
            end
        end
        if (sb_en && !rst && valid && !stall && !redirect) begin
            consumed++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got %h want none", instr);
            end else begin
                e = q.pop_front();
                chk("sb_instr", instr, e.instr);
                chk("sb_pc4", pc4, e.pc4);
            end
        end
        p_rst   = rst;
        p_stall = stall;
        p_redir = redirect;
        p_req   = mif.req;
        p_ack   = mif.ack;
        p_valid = valid;
        p_addr  = mif.addr;
        p_instr = instr;
        p_pc4   = pc4;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        nxt();
        neg();
        chk("rst_req", 32'(mif.req), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_req2", 32'(mif2.req), 32'h0);

        // Zero-wait streaming, plus wrap from RESET_PC=FFFF_FFFC
        key = 32'h0; fixed_wait = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("zw_addr", mif.addr, 32'(4 * i));
            if (i > 0) begin
                chk("zw_instr", instr, 32'(4 * (i - 1)));
                chk("zw_pc4", pc4, 32'(4 * i));
                chk("zw_valid", 32'(valid), 32'h1);
            end
            if (i == 0) chk("wrap_addr0", mif2.addr, 32'hFFFF_FFFC);
            if (i == 1) begin
                chk("wrap_addr1", mif2.addr, 32'h0);
                chk("wrap_pc4", pc42, 32'h0);
                chk("wrap_instr", instr2, 32'h3);
                chk("wrap_valid", 32'(valid2), 32'h1);
            end
            nxt();
        end

        // Two wait states
        fixed_wait = 2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("ws_addr", mif.addr, 32'h0);
            chk("ws_valid", 32'(valid), 32'h0);
            nxt();
        end
        neg();
        chk("ws_valid_on", 32'(valid), 32'h1);
        chk("ws_pc4", pc4, 32'h4);
        chk("ws_instr", instr, 32'h0);

        // Stall on the ack of word AB at address 8
        key = 32'hA3; fixed_wait = 0;
        do_reset();
        nxt();
        nxt();
        stall = 1'b1;
        nxt();
        neg();
        chk("sk_req", 32'(mif.req), 32'h0);
        chk("sk_instr", instr, 32'hA7);
        chk("sk_pc4", pc4, 32'h8);
        nxt();
        stall = 1'b0;
        neg();
        chk("sk_req_hold", 32'(mif.req), 32'h0);
        nxt();
        neg();
        chk("sk_out", instr, 32'hAB);
        chk("sk_out_pc4", pc4, 32'd12);
        chk("sk_addr", mif.addr, 32'd12);

        // Redirect while address 16 is pending
        key = 32'h0; slow_addr = 32'd16; slow_wait = 3;
        do_reset();
        repeat (4) nxt();
        redirect = 1'b1;
        rpc = 32'h43;
        neg();
        chk("sq_addr_c4", mif.addr, 32'd16);
        nxt();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("sq_addr_held", mif.addr, 32'd16);
            chk("sq_instr", instr, 32'h0);
            chk("sq_valid", 32'(valid), 32'h0);
            nxt();
        end
        neg();
        chk("sq_new_addr", mif.addr, 32'h40);
        chk("sq_valid_after", 32'(valid), 32'h0);
`ifdef FETCH_STATS_EN
        chk("sq_squash_cnt", scnt, 32'd1);
`endif
        nxt();
        neg();
        chk("sq_target_instr", instr, 32'h40);
        chk("sq_target_pc4", pc4, 32'h44);
        slow_addr = 32'h1;

        // Redirect together with Stall on a valid IF/ID
        do_reset();
        nxt();
        nxt();
        stall = 1'b1;
        redirect = 1'b1;
        rpc = 32'h100;
        neg();
        chk("rs_valid_before", 32'(valid), 32'h1);
        nxt();
        stall = 1'b0;
        redirect = 1'b0;
        neg();
        chk("rs_instr", instr, 32'h0);
        chk("rs_valid", 32'(valid), 32'h0);
        chk("rs_addr", mif.addr, 32'h100);
`ifdef FETCH_STATS_EN
        chk("rs_squash_cnt", scnt, 32'd1);
        chk("rs_fetch_cnt", fcnt, 32'd2);
`endif
        nxt();
        neg();
        chk("rs_target", instr, 32'h100);
        chk("rs_target_pc4", pc4, 32'h104);

        // Reset mid-wait
        fixed_wait = 3;
        do_reset();
        neg();
        chk("mr_req", 32'(mif.req), 32'h1);
        nxt();
        rst = 1'b1;
        neg();
        chk("mr_req_rst", 32'(mif.req), 32'h0);
        chk("mr_req2_rst", 32'(mif2.req), 32'h0);
        nxt();
        rst = 1'b0;
        neg();
        chk("mr_restart", mif.addr, 32'h0);
        chk("mr_restart_req", 32'(mif.req), 32'h1);
        chk("mr_restart2", mif2.addr, 32'hFFFF_FFFC);

        // Random stalls, redirects and wait states
        key = $urandom;
        fixed_wait = -1;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        q.delete();
        push_pc = 32'h0;
        refill();
        nxt();
        nxt();
        rst = 1'b0;
        sb_en = 1'b1;
        repeat (3000) begin
            nxt();
            redirect = ($urandom_range(0, 19) == 0);
            stall = ($urandom_range(0, 3) == 0);
            rpc = $urandom;
            if (redirect) begin
                q.delete();
                push_pc = rpc & ~32'h3;
            end
            refill();
        end
        nxt();
        stall = 1'b0;
        redirect = 1'b0;
        sb_en = 1'b0;
        neg();
        chk("rand_progress", 32'(consumed > 500), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the Control decoder: owns the PC, issues word reads to instruction memory, and drives the IF/ID register whose Instruction output feeds Control.
- Handles variable-latency memory, decode stalls, and branch/jump redirects (flush plus squash of in-flight reads).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- ADDR_WIDTH, 32, width of PC, ImemAddr, RedirectPC, PCPlus4

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- Stall  in  1  decode cannot accept; IF/ID holds
- Redirect  in  1  taken branch/jump from downstream
- RedirectPC  in  ADDR_WIDTH  new fetch address; bits [1:0] ignored, forced 0
- ImemReq  out  1  read request
- ImemAddr  out  ADDR_WIDTH  word-aligned read address
- ImemAck  in  1  read completes in the cycle it is high while ImemReq=1
- ImemData  in  32  read data, valid with ImemAck
- Instruction  out  32  IF/ID instruction to Control
- PCPlus4  out  ADDR_WIDTH  IF/ID PC+4 of Instruction
- InstrValid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (synchronous, active-high): PC=RESET_PC; ReqAddr=RESET_PC; Instruction=32'h0 (NOP); PCPlus4=0; InstrValid=0; ImemReq=0 during reset; state=FETCH on the first cycle after reset. Reset mid-transaction abandons it; a late ImemAck after reset is ignored unless ImemReq=1.
- Memory protocol: ImemAddr=ReqAddr, held stable while ImemReq=1 until ImemAck. Ack may arrive in the same cycle as the request (zero wait states).
- Throughput: 1 instruction/cycle with zero-wait memory. Latency: ImemAck cycle to Instruction/InstrValid visible is 1 clock.
- Arithmetic: PC+4 modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC wraps to 0.
- State FETCH (ImemReq=1):
  - Redirect with ImemAck: discard data; PC=ReqAddr=RedirectPC; stay FETCH.
  - Redirect without ImemAck: PC=RedirectPC; go SQUASH (ReqAddr held).
  - ImemAck and !Stall: Instruction=ImemData; PCPlus4=ReqAddr+4; InstrValid=1; PC=ReqAddr=ReqAddr+4.
  - ImemAck and Stall: capture ImemData into the skid buffer; PC=ReqAddr=ReqAddr+4; go HOLD.
  - No ack and !Stall: InstrValid=0 (bubble). No ack and Stall: IF/ID unchanged.
- State SQUASH (ImemReq=1, old ReqAddr):
  - On ImemAck: discard data; ReqAddr=PC; go FETCH.
  - Further Redirect: updates PC only (last redirect wins).
- State HOLD (ImemReq=0):
  - !Stall: IF/ID loads from the skid buffer (InstrValid=1); go FETCH.
  - Redirect: drop buffer; PC=ReqAddr=RedirectPC; go FETCH.
- Flush: in any state, Redirect forces Instruction=0, InstrValid=0 next cycle. Redirect overrides Stall.
- Stall with no Redirect: Instruction, PCPlus4, and InstrValid never change.
- Stall-state contract: FETCH issues at most one outstanding request; the skid buffer is one entry, so no data is lost.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds outputs FetchCount[31:0] (instructions loaded into IF/ID) and SquashCount[31:0] (reads discarded in FETCH-with-ack or SQUASH). Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg: state encoding (FETCH, SQUASH, HOLD), NOP_INSTR=32'h0, default RESET_PC.
- One sub-module if_id_reg: Instruction/PCPlus4/InstrValid register with load, hold (Stall), and flush (Redirect) controls.

Test Plan:
- Reset, then zero-wait memory returning ImemData=ImemAddr: ImemAddr sequence 0,4,8,12; Instruction=0,4,8 one cycle later; InstrValid=1 continuously.
- Memory with 2 wait states: ImemAddr stays 0 for 3 cycles; InstrValid=0 in the bubble cycles; PCPlus4=4 when Instruction is valid.
- Stall asserted the cycle ImemAck returns word 8'hAB at addr 8: state HOLD, ImemReq=0, IF/ID unchanged. Deassert Stall: Instruction=8'hAB, PCPlus4=12; next ImemAddr=12.
- Redirect to 32'h40 while addr 16 is pending without ack: SQUASH, ImemAddr held at 16; ack discarded (IF/ID stays NOP); next ImemAddr=32'h40; InstrValid=0 until 32'h40 returns.
- Redirect and Stall asserted together with valid IF/ID: Instruction=0 and InstrValid=0 next cycle. With FETCH_STATS_EN, SquashCount increments once per discarded ack.
- RESET_PC=32'hFFFF_FFFC: first ImemAddr=32'hFFFF_FFFC, PCPlus4=0, next ImemAddr=0. Reset asserted mid-wait: ImemReq=0 that cycle; restart at RESET_PC.
